store_merge: RTL and testbench

- Write-side counterpart of the load data path: turns a store instruction (sb, sh, sw) into full 32-bit word writes for a data memory that has no byte enables.
- Sub-word stores run a read-modify-write sequence: read the aligned word, merge the new byte or halfword into the correct little-endian lane, then write the word back.
- Sits between the CPU's store datapath and the data memory port. The CPU stalls while busy is high.

---
 rtl/store_merge.sv | 130 +++++++++++++
 tb/tb_store_merge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/store_merge.sv
// Store unit for a word-only data memory: sw writes directly, sb/sh run a
// read-modify-write that merges the new lane into the word read back.
module store_merge #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data_in,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] mem_address,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY - 1);

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [3:0]  wait_cnt;

  function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return off[0];
      3'b010:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Little-endian lane replacement; only sb and sh reach this path.
  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [15:0] wd,
                                             input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] w;
    w = old;
    if (f3 == 3'b001) begin
      if (off[1]) w[31:16] = wd;
      else        w[15:0]  = wd;
    end else begin
      case (off)
        2'd0: w[7:0]   = wd[7:0];
        2'd1: w[15:8]  = wd[7:0];
        2'd2: w[23:16] = wd[7:0];
        2'd3: w[31:24] = wd[7:0];
      endcase
    end
    return w;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      mem_address      <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
      f3_q             <= '0;
      off_q            <= '0;
      wdata_q          <= '0;
      wait_cnt         <= '0;
    end else begin
      done             <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f3_q        <= funct3;
            off_q       <= address[1:0];
            wdata_q     <= write_data_in[15:0];
            mem_address <= {address[31:2], 2'b00};
            busy        <= 1'b1;
            if (is_illegal(funct3, address[1:0])) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else if (funct3 == 3'b010) begin
              state            <= WRITE;
              mem_write_enable <= 1'b1;
              mem_write_data   <= write_data_in;
              error            <= 1'b0;
            end else begin
              state           <= READ;
              mem_read_enable <= 1'b1;
              error           <= 1'b0;
            end
          end
        end
        READ: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          // Read data is valid in the final WAIT cycle only.
          if (wait_cnt == WAIT_LAST) begin
            mem_write_data   <= merge_word(mem_read_data, wdata_q, f3_q, off_q);
            mem_write_enable <= 1'b1;
            state            <= WRITE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge.sv
// Directed bench for store_merge with a fixed-latency memory read model.
module tb_store_merge;

  localparam int READ_LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] address = '0;
  logic [31:0] write_data_in = '0;
  logic [31:0] mem_read_data;
  logic        busy, done, error;
  logic [31:0] mem_address;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_write_data;

  logic [31:0]         mem_word = 32'h1122_3344;
  logic [READ_LAT-1:0] rd_pipe = '0;

  int checks = 0;
  int errors = 0;

  store_merge #(.READ_LATENCY(READ_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .funct3(funct3),
    .address(address), .write_data_in(write_data_in), .mem_read_data(mem_read_data),
    .busy(busy), .done(done), .error(error), .mem_address(mem_address),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data)
  );

  always #5 clock = ~clock;

  // Memory returns the word exactly READ_LAT cycles after the read strobe.
  always @(posedge clock) rd_pipe <= {rd_pipe[READ_LAT-2:0], mem_read_enable};
  assign mem_read_data = rd_pipe[READ_LAT-1] ? mem_word : 32'hBAD0_BAD0;

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output int done_cyc, output int wr_cyc,
                        output int n_rd, output int n_wr, output logic err,
                        output logic [31:0] wa, output logic [31:0] wd, output int busy_low);
    funct3 = f3; address = a; write_data_in = d; start = 1'b1;
    done_cyc = -1; wr_cyc = -1; n_rd = 0; n_wr = 0; err = 1'b0; wa = '0; wd = '0; busy_low = 0;
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(posedge clock); #1;
      if (!hold) begin
        start = 1'b0; address = 32'hFFFF_FFFF; write_data_in = 32'h0; funct3 = 3'b000;
      end
      if (!busy) busy_low++;
      if (mem_read_enable) n_rd++;
      if (mem_write_enable) begin n_wr++; wr_cyc = c; wa = mem_address; wd = mem_write_data; end
      if (done) begin done_cyc = c; err = error; end
    end
    @(posedge clock); #1;
    if (mem_read_enable) n_rd++;
    if (mem_write_enable) n_wr++;
  endtask

  task automatic test_reset();
    int dc, wc, nr, nw, bl, seen;
    logic e;
    logic [31:0] wa, wd;
    checks++;
    if ({busy, done, error, mem_read_enable, mem_write_enable} !== 5'b0 ||
        mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      errors++; $display("FAIL reset_initial: ctrl=%b addr=%h wdata=%h required zeros",
                         {busy, done, error, mem_read_enable, mem_write_enable}, mem_address, mem_write_data);
    end
    @(posedge clock); #1; reset = 1'b0;
    mem_word = 32'h1122_3344;
    funct3 = 3'b000; address = 32'h203; write_data_in = 32'hFFFF_FFAB; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, mem_read_enable, mem_write_enable} !== 5'b0 ||
        mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      errors++; $display("FAIL reset_mid_wait: ctrl=%b addr=%h wdata=%h required zeros",
                         {busy, done, error, mem_read_enable, mem_write_enable}, mem_address, mem_write_data);
    end
    @(posedge clock); #1; reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (mem_write_enable || done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_abandon: activity cycles %0d required 0", seen);
    end
    run_op(3'b000, 32'h203, 32'hFFFF_FFAB, 1'b0, dc, wc, nr, nw, e, wa, wd, bl);
    checks++;
    if (wd !== 32'hAB22_3344 || dc !== READ_LAT + 3 || nw !== 1) begin
      errors++; $display("FAIL reset_recover: wdata=%h done=%0d writes=%0d required ab223344/%0d/1",
                         wd, dc, nw, READ_LAT + 3);
    end
  endtask

  task automatic test_sw();
    int dc, wc, nr, nw, bl;
    logic e;
    logic [31:0] wa, wd;
    run_op(3'b010, 32'h100, 32'hDEAD_BEEF, 1'b0, dc, wc, nr, nw, e, wa, wd, bl);
    checks++;
    if (wc !== 1 || wa !== 32'h100 || wd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_write: cyc=%0d addr=%h data=%h required 1/00000100/deadbeef", wc, wa, wd);
    end
    checks++;
    if (dc !== 2 || e !== 1'b0 || nr !== 0 || nw !== 1 || bl !== 0) begin
      errors++; $display("FAIL sw_ctrl: done=%0d err=%b reads=%0d writes=%0d busylow=%0d required 2/0/0/1/0",
                         dc, e, nr, nw, bl);
    end
  endtask

  task automatic test_sb_lanes();
    int dc, wc, nr, nw, bl;
    logic e;
    logic [31:0] wa, wd;
    logic [31:0] addrs [4] = '{32'h203, 32'h200, 32'h201, 32'h202};
    logic [31:0] exps  [4] = '{32'hAB22_3344, 32'h1122_33AB, 32'h1122_AB44, 32'h11AB_3344};
    mem_word = 32'h1122_3344;
    for (int i = 0; i < 4; i++) begin
      run_op(3'b000, addrs[i], 32'hFFFF_FFAB, 1'b0, dc, wc, nr, nw, e, wa, wd, bl);
      checks++;
      if (wd !== exps[i] || wa !== 32'h200) begin
        errors++; $display("FAIL sb_lane%0d: data=%h addr=%h required %h/00000200", i, wd, wa, exps[i]);
      end
      checks++;
      if (dc !== READ_LAT + 3 || wc !== READ_LAT + 2 || e !== 1'b0 || nr !== 1 || nw !== 1) begin
        errors++; $display("FAIL sb_timing%0d: done=%0d wr=%0d err=%b reads=%0d writes=%0d required %0d/%0d/0/1/1",
                           i, dc, wc, e, nr, nw, READ_LAT + 3, READ_LAT + 2);
      end
    end
  endtask

  task automatic test_sh();
    int dc, wc, nr, nw, bl;
    logic e;
    logic [31:0] wa, wd;
    mem_word = 32'h1122_3344;
    run_op(3'b001, 32'h302, 32'h0000_BEEF, 1'b0, dc, wc, nr, nw, e, wa, wd, bl);
    checks++;
    if (wd !== 32'hBEEF_3344 || wa !== 32'h300 || dc !== READ_LAT + 3 || e !== 1'b0) begin
      errors++; $display("FAIL sh_upper: data=%h addr=%h done=%0d err=%b required beef3344/00000300/%0d/0",
                         wd, wa, dc, e, READ_LAT + 3);
    end
    run_op(3'b001, 32'h300, 32'h0000_BEEF, 1'b0, dc, wc, nr, nw, e, wa, wd, bl);
    checks++;
    if (wd !== 32'h1122_BEEF || wa !== 32'h300 || dc !== READ_LAT + 3 || e !== 1'b0) begin
      errors++; $display("FAIL sh_lower: data=%h addr=%h done=%0d err=%b required 1122beef/00000300/%0d/0",
                         wd, wa, dc, e, READ_LAT + 3);
    end
  endtask

  task automatic test_errors();
    int dc, wc, nr, nw, bl;
    logic e;
    logic [31:0] wa, wd;
    logic [2:0]  f3s   [3] = '{3'b001, 3'b010, 3'b011};
    logic [31:0] addrs [3] = '{32'h101, 32'h102, 32'h100};
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], addrs[i], 32'h1234_5678, 1'b0, dc, wc, nr, nw, e, wa, wd, bl);
      checks++;
      if (dc !== 1 || e !== 1'b1 || nr !== 0 || nw !== 0) begin
        errors++; $display("FAIL err_case%0d: done=%0d err=%b reads=%0d writes=%0d required 1/1/0/0",
                           i, dc, e, nr, nw);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc, wc, nr, nw, bl;
    logic e;
    logic [31:0] wa, wd;
    mem_word = 32'h1122_3344;
    run_op(3'b000, 32'h203, 32'hFFFF_FFAB, 1'b1, dc, wc, nr, nw, e, wa, wd, bl);
    checks++;
    if (dc !== 6 || nr !== 1 || nw !== 1 || bl !== 0 || wd !== 32'hAB22_3344) begin
      errors++; $display("FAIL busy_held: done=%0d reads=%0d writes=%0d busylow=%0d data=%h required 6/1/1/0/ab223344",
                         dc, nr, nw, bl, wd);
    end
    run_op(3'b000, 32'h200, 32'hFFFF_FFAB, 1'b0, dc, wc, nr, nw, e, wa, wd, bl);
    checks++;
    if (dc !== 6 || nw !== 1 || wd !== 32'h1122_33AB) begin
      errors++; $display("FAIL back_to_back: done=%0d writes=%0d data=%h required 6/1/112233ab", dc, nw, wd);
    end
    checks++;
    if (mem_write_data !== 32'h1122_33AB || mem_address !== 32'h200 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_after: data=%h addr=%h busy=%b required 112233ab/00000200/0",
                         mem_write_data, mem_address, busy);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sw();
    test_sb_lanes();
    test_sh();
    test_errors();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
